instr_prefetch_buffer: RTL

Fetch-stage instruction prefetch queue between instruction memory and the pipelined datapath. Issues sequential word fetches ahead of the pipeline over a variable-latency req/ack memory port and buffers up to DEPTH instructions. Presents InstrF for the current PCF and raises a fetch stall when that instruction is not yet held. Detects control-flow redirects (branch, PC write in writeback) as a PCF mismatch and flushes.

---
 rtl/instr_prefetch_buffer_pkg.sv | 27 ++
 rtl/instr_prefetch_buffer_fetch_queue.sv | 89 ++++++++
 rtl/instr_prefetch_buffer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_buffer_pkg.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer_pkg
// Shared definitions for the fetch-stage instruction prefetch buffer:
//   - fetch_state_e   : memory-port request state (IDLE / BUSY / DISCARD)
//   - queue_entry_t   : one buffered instruction tagged with its word address
//   - WORD_AW         : width of a word address (byte address bits [31:2])
//   - DEFAULT_*       : default reset PC and the "no instruction" encoding
// ---------------------------------------------------------------------------
package instr_prefetch_buffer_pkg;

   localparam int unsigned WORD_AW = 30;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,   // no request outstanding
      BUSY    = 2'd1,   // request outstanding, returning data is kept
      DISCARD = 2'd2    // request outstanding, returning data is dropped
   } fetch_state_e;

   typedef struct packed {
      logic [WORD_AW-1:0] addr;
      logic [31:0]        instr;
   } queue_entry_t;

endpackage : instr_prefetch_buffer_pkg

// File: rtl/instr_prefetch_buffer_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer_fetch_queue
// Circular FIFO of {word address, instruction} entries for the prefetch
// buffer. The head (oldest entry) is presented combinationally.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   push          write push_entry at the tail this cycle
//   push_entry    entry to write
//   pop           remove the head this cycle
//   clear         empty the queue (overrides push and pop)
//   head          oldest entry (undefined contents when empty)
//   empty, full   occupancy flags
//   count         number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module instr_prefetch_buffer_fetch_queue
   import instr_prefetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  queue_entry_t  push_entry,
   input  logic          pop,
   input  logic          clear,
   output queue_entry_t  head,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   queue_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; validity is tracked
   // by count_q alone, which keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (push && !clear) mem_q[wr_ptr_q] <= push_entry;
   end

   assign head  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_C);
   assign count = count_q;

endmodule : instr_prefetch_buffer_fetch_queue

// File: rtl/instr_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer
// Fetch-stage prefetch queue. Issues sequential word fetches ahead of the
// pipeline over a req/ack memory port, buffers up to DEPTH instructions and
// presents the instruction for PCF. A PCF that does not match the address
// the buffer expects next is a redirect: the queue is flushed and fetching
// restarts at PCF; an in-flight request is allowed to finish but its data
// is dropped.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   PCF           current fetch PC
//   StallF        fetch stall; when low a valid instruction is consumed
//   InstrF        instruction for PCF, NOP_INSTR when not valid
//   InstrValidF   InstrF is valid for PCF
//   FetchStallF   stall request to the hazard unit (~InstrValidF)
//   imem_req      registered memory request, held until imem_ack
//   imem_addr     registered word-aligned request address
//   imem_ack      one-cycle pulse, imem_rdata valid
//   imem_rdata    fetched instruction
// ---------------------------------------------------------------------------
module instr_prefetch_buffer
   import instr_prefetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF,
   input  logic        StallF,
   output logic [31:0] InstrF,
   output logic        InstrValidF,
   output logic        FetchStallF,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata
);

   localparam int unsigned   CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_e       state_q,      state_d;
   logic [WORD_AW-1:0] out_addr_q,   out_addr_d;    // address of the outstanding request
   logic [WORD_AW-1:0] fetch_addr_q, fetch_addr_d;  // next address to request

   logic               q_push, q_pop, q_clear;
   logic               q_empty, q_full;
   logic [CW-1:0]      q_count;
   logic [CW-1:0]      count_next;
   queue_entry_t       q_head, q_push_entry;

   logic [WORD_AW-1:0] pcf_word;
   logic [WORD_AW-1:0] expected_addr;
   logic               hit, redirect, room, issue;

   // Only the word address takes part in matching.
   assign pcf_word = PCF[31:2];
   logic  unused_pcf_lsbs;
   assign unused_pcf_lsbs = ^PCF[1:0];

   // The address the buffer will deliver next: the head if anything is
   // buffered, else the outstanding request, else the next fetch.
   always_comb begin
      if (!q_empty)              expected_addr = q_head.addr;
      else if (state_q != IDLE)  expected_addr = out_addr_q;
      else                       expected_addr = fetch_addr_q;
   end

   assign redirect = (pcf_word != expected_addr);
   assign hit      = !q_empty && (q_head.addr == pcf_word);

   // Pop and push are both suppressed by the flush on a redirect.
   assign q_pop    = hit && !StallF && !redirect;
   assign q_push   = (state_q == BUSY) && imem_ack && !redirect;
   assign q_clear  = redirect;
   assign q_push_entry = '{addr: out_addr_q, instr: imem_rdata};

   // Occupancy after this cycle's push/pop must leave space for one more
   // in-flight word, so an ack can never land on a full queue.
   assign count_next = q_count + CW'(q_push) - CW'(q_pop);
   assign room       = (count_next < DEPTH_C);

   always_comb begin
      state_d      = state_q;
      out_addr_d   = out_addr_q;
      fetch_addr_d = fetch_addr_q;
      issue        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (redirect)   fetch_addr_d = pcf_word;
            else if (room)  issue        = 1'b1;
         end
         BUSY: begin
            if (redirect) begin
               fetch_addr_d = pcf_word;
               state_d      = imem_ack ? IDLE : DISCARD;
            end else if (imem_ack) begin
               // Back-to-back issue when the pushed word leaves room.
               if (room) issue   = 1'b1;
               else      state_d = IDLE;
            end
         end
         DISCARD: begin
            if (redirect) fetch_addr_d = pcf_word;
            if (imem_ack) state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         state_d      = BUSY;
         out_addr_d   = fetch_addr_q;
         fetch_addr_d = fetch_addr_q + 1'b1;   // wraps modulo 2^32 bytes
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         out_addr_q   <= '0;
         fetch_addr_q <= RESET_PC[31:2];
      end else begin
         state_q      <= state_d;
         out_addr_q   <= out_addr_d;
         fetch_addr_q <= fetch_addr_d;
      end
   end

   instr_prefetch_buffer_fetch_queue #(
      .DEPTH (DEPTH)
   ) u_fetch_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (q_push),
      .push_entry (q_push_entry),
      .pop        (q_pop),
      .clear      (q_clear),
      .head       (q_head),
      .empty      (q_empty),
      .full       (q_full),
      .count      (q_count)
   );

   // The room rule guarantees a push into a full queue always pairs with a pop.
   assert property (@(posedge clk) disable iff (reset) !(q_push && q_full && !q_pop));

   // Request outputs come straight from flops, so they are registered and
   // stay stable for the whole request.
   assign imem_req    = (state_q != IDLE);
   assign imem_addr   = {out_addr_q, 2'b00};

   assign InstrValidF = hit;
   assign FetchStallF = ~hit;
   assign InstrF      = hit ? q_head.instr : NOP_INSTR;

endmodule : instr_prefetch_buffer
